// File: rtl/parity_gen_chk.sv
// parity_gen_chk: pipelined parity generator and checker for DATA_W-bit words.
//
// Generator: one register stage with a valid/ready stream on each side. The
// parity bit is placed in the MSB of out_word: {parity, payload}.
// Checker: flags a parity error one cycle after a bad word arrives and keeps
// a saturating error count with a synchronous clear.
//
// Optional feature, enabled by defining PARITY_ERR_INJECT_EN:
//   adds input err_inject; when high on an accept cycle the stored parity bit
//   is inverted (payload unchanged). With the macro undefined the port is
//   absent and generated parity is always correct.
//
// Handshake: a transfer happens on a rising clk edge when valid and ready are
// both high; valid must not depend on ready; once out_valid is high, out_word
// and out_valid stay stable until out_ready is seen high; the checker side has
// no backpressure, so every chk_valid cycle is a transfer.

module parity_gen_chk #(
  parameter int DATA_W    = 4,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mode_odd,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_W-1:0]    in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_W:0]      out_word,
  input  logic                 chk_valid,
  input  logic [DATA_W:0]      chk_word,
  output logic                 chk_err,
  input  logic                 err_clr,
  output logic [ERR_CNT_W-1:0] err_count
`ifdef PARITY_ERR_INJECT_EN
  ,
  input  logic                 err_inject
`endif
);

  localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;
  localparam logic [ERR_CNT_W-1:0] CNT_ONE = ERR_CNT_W'(1);

  logic accept;
  logic gen_parity;
  logic bad;

  // The stage can take a word when it is empty or its word leaves this cycle.
  assign in_ready = ~out_valid | out_ready;
  assign accept   = in_valid & in_ready;

  // Parity bit for the word being accepted; XOR with mode_odd turns even into odd.
  always_comb begin
    gen_parity = (^in_data) ^ mode_odd;
`ifdef PARITY_ERR_INJECT_EN
    gen_parity = gen_parity ^ err_inject;
`endif
  end

  // Output register: load on accept, drop valid once drained, hold while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_word  <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_word  <= {gen_parity, in_data};
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // A received word is bad when its ones-count parity disagrees with the mode.
  always_comb begin
    bad = chk_valid & ((^chk_word) != mode_odd);
  end

  // Error pulse follows the bad flag by one cycle and is never sticky.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chk_err <= 1'b0;
    end else begin
      chk_err <= bad;
    end
  end

  // Saturating error counter; clear wins but the same-cycle error still counts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count <= '0;
    end else if (err_clr) begin
      err_count <= bad ? CNT_ONE : '0;
    end else if (bad && (err_count != CNT_MAX)) begin
      err_count <= err_count + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_parity_gen_chk.sv
// tb_parity_gen_chk: directed and randomized checks of parity_gen_chk with
// DATA_W=4 and ERR_CNT_W=2. Inputs change 1 ns after a rising edge; outputs
// are sampled 1-2 ns after a rising edge.

module tb_parity_gen_chk;

  localparam int DW = 4;
  localparam int CW = 2;
  localparam logic [CW-1:0] CNT_SAT = CW'((1 << CW) - 1);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          mode_odd;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW:0]   out_word;
  logic          chk_valid;
  logic [DW:0]   chk_word;
  logic          chk_err;
  logic          err_clr;
  logic [CW-1:0] err_count;
`ifdef PARITY_ERR_INJECT_EN
  logic          err_inject;
`endif

  parity_gen_chk #(.DATA_W(DW), .ERR_CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode_odd  (mode_odd),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_word  (out_word),
    .chk_valid (chk_valid),
    .chk_word  (chk_word),
    .chk_err   (chk_err),
    .err_clr   (err_clr),
    .err_count (err_count)
`ifdef PARITY_ERR_INJECT_EN
    ,
    .err_inject(err_inject)
`endif
  );

  int check_cnt = 0;
  int pass_cnt  = 0;

  // ---------------- reference model ----------------
  // Parity bit chosen so the whole word's count of ones is even (even mode)
  // or odd (odd mode); inject flips it.
  function automatic logic [DW:0] model_word(input logic [DW-1:0] d, input logic odd,
                                              input logic inj);
    int  ones;
    int  target;
    logic p;
    ones   = $countones(d);
    target = odd ? 1 : 0;
    p      = ((ones % 2) != target);
    if (inj) p = ~p;
    return {p, d};
  endfunction

  function automatic logic model_bad(input logic [DW:0] w, input logic odd);
    int target;
    target = odd ? 1 : 0;
    return (($countones(w) % 2) != target);
  endfunction

  logic [DW:0] exp_q[$];

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    mode_odd  = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    chk_valid = 1'b0;
    chk_word  = '0;
    err_clr   = 1'b0;
`ifdef PARITY_ERR_INJECT_EN
    err_inject = 1'b0;
`endif
  endtask

  // Drain the generator and zero the counter.
  task automatic settle();
    drive_idle();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    step();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    drive_idle();
    rst = 1'b1;
    #1;
    check_cnt++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b want=1", in_ready);
    else pass_cnt++;
    step();
    step();
    check_cnt++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b want=0", out_valid);
    else pass_cnt++;
    check_cnt++;
    if (out_word !== '0) $display("FAIL reset_out_word got=%h want=0", out_word);
    else pass_cnt++;
    check_cnt++;
    if (chk_err !== 1'b0) $display("FAIL reset_chk_err got=%b want=0", chk_err);
    else pass_cnt++;
    check_cnt++;
    if (err_count !== '0) $display("FAIL reset_err_count got=%0d want=0", err_count);
    else pass_cnt++;
    rst = 1'b0;
    step();
  endtask

  task automatic test_gen_modes();
    settle();
    in_valid = 1'b1;
    in_data  = 4'b1011;
    mode_odd = 1'b0;
    step();
    check_cnt++;
    if (out_valid !== 1'b1) $display("FAIL gen_even_valid got=%b want=1", out_valid);
    else pass_cnt++;
    check_cnt++;
    if (out_word !== 5'b11011) $display("FAIL gen_even_word got=%b want=11011", out_word);
    else pass_cnt++;
    mode_odd = 1'b1;
    step();
    check_cnt++;
    if (out_word !== 5'b01011) $display("FAIL gen_odd_word got=%b want=01011", out_word);
    else pass_cnt++;
    in_valid = 1'b0;
    mode_odd = 1'b0;
    step();
    check_cnt++;
    if (out_valid !== 1'b0) $display("FAIL gen_drain_valid got=%b want=0", out_valid);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] seq [3];
    logic [DW:0]   want [3];
    seq[0] = 4'h0; seq[1] = 4'h1; seq[2] = 4'h3;
    want[0] = 5'h00; want[1] = 5'h11; want[2] = 5'h03;
    settle();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = seq[i];
      #1;
      check_cnt++;
      if (in_ready !== 1'b1) $display("FAIL b2b_in_ready[%0d] got=%b want=1", i, in_ready);
      else pass_cnt++;
      step();
      check_cnt++;
      if (out_word !== want[i] || out_valid !== 1'b1)
        $display("FAIL b2b_word[%0d] got=%h/v%b want=%h/v1", i, out_word, out_valid, want[i]);
      else pass_cnt++;
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_backpressure();
    settle();
    in_valid = 1'b1;
    in_data  = 4'h7;
    step();
    check_cnt++;
    if (out_word !== 5'h17) $display("FAIL bp_first_word got=%h want=17", out_word);
    else pass_cnt++;
    out_ready = 1'b0;
    in_data   = 4'h2;
    for (int i = 0; i < 3; i++) begin
      mode_odd = i[0];   // mode flips must not disturb the held word
      #1;
      check_cnt++;
      if (in_ready !== 1'b0) $display("FAIL bp_in_ready[%0d] got=%b want=0", i, in_ready);
      else pass_cnt++;
      step();
      check_cnt++;
      if (out_word !== 5'h17 || out_valid !== 1'b1)
        $display("FAIL bp_hold[%0d] got=%h/v%b want=17/v1", i, out_word, out_valid);
      else pass_cnt++;
    end
    mode_odd  = 1'b0;
    out_ready = 1'b1;
    #1;
    check_cnt++;
    if (in_ready !== 1'b1) $display("FAIL bp_release_ready got=%b want=1", in_ready);
    else pass_cnt++;
    step();
    check_cnt++;
    if (out_word !== 5'h12 || out_valid !== 1'b1)
      $display("FAIL bp_next_word got=%h/v%b want=12/v1", out_word, out_valid);
    else pass_cnt++;
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_checker();
    logic [DW:0] words [3];
    logic        want_err [3];
    logic [CW-1:0] want_cnt [3];
    words[0] = 5'b00011; words[1] = 5'b00111; words[2] = 5'b10111;
    want_err[0] = 1'b0;  want_err[1] = 1'b1;  want_err[2] = 1'b0;
    want_cnt[0] = 2'd0;  want_cnt[1] = 2'd1;  want_cnt[2] = 2'd1;
    settle();
    for (int i = 0; i < 3; i++) begin
      chk_valid = 1'b1;
      chk_word  = words[i];
      step();
      check_cnt++;
      if (chk_err !== want_err[i])
        $display("FAIL chk_err[%0d] got=%b want=%b", i, chk_err, want_err[i]);
      else pass_cnt++;
      check_cnt++;
      if (err_count !== want_cnt[i])
        $display("FAIL chk_count[%0d] got=%0d want=%0d", i, err_count, want_cnt[i]);
      else pass_cnt++;
    end
    chk_valid = 1'b0;
    step();
    check_cnt++;
    if (chk_err !== 1'b0) $display("FAIL chk_pulse_end got=%b want=0", chk_err);
    else pass_cnt++;
  endtask

  task automatic test_saturation();
    settle();
    chk_valid = 1'b1;
    chk_word  = 5'b00001;
    for (int i = 1; i <= 5; i++) begin
      step();
      check_cnt++;
      if (err_count !== ((i > 3) ? CNT_SAT : CW'(i)))
        $display("FAIL sat_count[%0d] got=%0d want=%0d", i, err_count, (i > 3) ? 3 : i);
      else pass_cnt++;
    end
    err_clr = 1'b1;
    step();
    check_cnt++;
    if (err_count !== 2'd1) $display("FAIL sat_clr_bad got=%0d want=1", err_count);
    else pass_cnt++;
    chk_valid = 1'b0;
    step();
    check_cnt++;
    if (err_count !== 2'd0) $display("FAIL sat_clr_only got=%0d want=0", err_count);
    else pass_cnt++;
    err_clr = 1'b0;
    chk_word = 5'b00001;   // bad pattern but not valid: must not count
    step();
    check_cnt++;
    if (err_count !== 2'd0 || chk_err !== 1'b0)
      $display("FAIL sat_invalid got=%0d/%b want=0/0", err_count, chk_err);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    settle();
    in_valid  = 1'b1;
    in_data   = 4'h5;
    out_ready = 1'b0;
    chk_valid = 1'b1;
    chk_word  = 5'b00001;
    step();
    in_valid = 1'b0;
    step();
    check_cnt++;
    if (out_valid !== 1'b1 || err_count !== 2'd2 || chk_err !== 1'b1)
      $display("FAIL rmid_pre got=v%b/c%0d/e%b want=v1/c2/e1", out_valid, err_count, chk_err);
    else pass_cnt++;
    #1;
    rst = 1'b1;   // mid-cycle, no clock edge follows before the checks
    #1;
    check_cnt++;
    if (out_valid !== 1'b0 || out_word !== '0)
      $display("FAIL rmid_gen got=v%b/%h want=v0/00", out_valid, out_word);
    else pass_cnt++;
    check_cnt++;
    if (err_count !== '0 || chk_err !== 1'b0)
      $display("FAIL rmid_chk got=c%0d/e%b want=c0/e0", err_count, chk_err);
    else pass_cnt++;
    drive_idle();
    #1;
    rst = 1'b0;
    step();
  endtask

`ifdef PARITY_ERR_INJECT_EN
  task automatic test_inject();
    settle();
    in_valid   = 1'b1;
    in_data    = 4'b1011;
    err_inject = 1'b1;
    step();
    check_cnt++;
    if (out_word !== 5'b01011) $display("FAIL inject_word got=%b want=01011", out_word);
    else pass_cnt++;
    err_inject = 1'b0;
    in_valid   = 1'b0;
    step();
  endtask
`endif

  // Random traffic on both paths at once, scored against the queue model.
  task automatic test_random();
    logic          exp_ready;
    logic          bad_now;
    logic [CW-1:0] model_cnt;
    exp_q.delete();
    settle();
    model_cnt = '0;
    for (int n = 0; n < 400; n++) begin
      mode_odd  = 1'($urandom_range(0, 1));
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = DW'($urandom_range(0, (1 << DW) - 1));
      out_ready = ($urandom_range(0, 3) != 0);
      chk_valid = 1'($urandom_range(0, 1));
      chk_word  = (DW + 1)'($urandom_range(0, (1 << (DW + 1)) - 1));
      err_clr   = ($urandom_range(0, 7) == 0);
      #1;
      exp_ready = (exp_q.size() == 0) || out_ready;
      check_cnt++;
      if (in_ready !== exp_ready)
        $display("FAIL rnd_in_ready[%0d] got=%b want=%b", n, in_ready, exp_ready);
      else pass_cnt++;
      check_cnt++;
      if (out_valid !== (exp_q.size() != 0))
        $display("FAIL rnd_out_valid[%0d] got=%b want=%b", n, out_valid, exp_q.size() != 0);
      else pass_cnt++;
      if (exp_q.size() != 0) begin
        check_cnt++;
        if (out_word !== exp_q[0])
          $display("FAIL rnd_out_word[%0d] got=%h want=%h", n, out_word, exp_q[0]);
        else pass_cnt++;
      end
      bad_now = chk_valid && model_bad(chk_word, mode_odd);
      if (err_clr) model_cnt = bad_now ? CW'(1) : '0;
      else if (bad_now && model_cnt != CNT_SAT) model_cnt = model_cnt + CW'(1);
      if (out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
      if (in_valid && exp_ready) exp_q.push_back(model_word(in_data, mode_odd, 1'b0));
      step();
      check_cnt++;
      if (chk_err !== bad_now)
        $display("FAIL rnd_chk_err[%0d] got=%b want=%b", n, chk_err, bad_now);
      else pass_cnt++;
      check_cnt++;
      if (err_count !== model_cnt)
        $display("FAIL rnd_err_count[%0d] got=%0d want=%0d", n, err_count, model_cnt);
      else pass_cnt++;
    end
    drive_idle();
    step();
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "simulation time limit");
  end

  // ---------------- sequence and report ----------------
  initial begin
    drive_idle();
    rst = 1'b1;
    test_reset();
    test_gen_modes();
    test_back_to_back();
    test_backpressure();
    test_checker();
    test_saturation();
    test_reset_mid();
`ifdef PARITY_ERR_INJECT_EN
    test_inject();
`endif
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
